// File: rtl/game_defs_pkg.sv
// Shared game-level definitions: state encodings and pixel geometry widths.
package game_defs;

   localparam int unsigned COLOR_W = 12;
   localparam int unsigned X_W     = 10;
   localparam int unsigned Y_W     = 9;
   localparam int unsigned HALF_W  = 8;

   typedef enum logic [1:0] {
      GAME_INITIAL = 2'b00,
      GAME_RUNNING = 2'b01,
      GAME_OVER    = 2'b10,
      GAME_SUCCESS = 2'b11
   } game_state_t;

endpackage

// File: rtl/sprite_hit_test.sv
// Combinational box and transparency test for one sprite channel.
// Offsets are taken one bit wider than the coordinate so a sprite near the
// screen edge is clipped rather than wrapping around to the opposite side.
module sprite_hit_test #(
   parameter int unsigned          COLOR_W   = game_defs::COLOR_W,
   parameter logic [COLOR_W-1:0]   TRANS_KEY = '0
) (
   input  logic                          en,
   input  logic [game_defs::X_W-1:0]     x,
   input  logic [game_defs::Y_W-1:0]     y,
   input  logic [game_defs::X_W-1:0]     cx,
   input  logic [game_defs::Y_W-1:0]     cy,
   input  logic [game_defs::HALF_W-1:0]  hw,
   input  logic [game_defs::HALF_W-1:0]  hh,
   input  logic [COLOR_W-1:0]            color,
   output logic                          hit_c
);
   import game_defs::*;

   localparam int unsigned RX_W = X_W + 1;
   localparam int unsigned RY_W = Y_W + 1;

   logic [RX_W-1:0] rel_x;
   logic [RY_W-1:0] rel_y;
   logic            in_x;
   logic            in_y;

   // Offset from the box's top-left corner; MSB set means left of / above the box.
   always_comb begin
      rel_x = RX_W'(x) + RX_W'(hw) - RX_W'(cx);
      rel_y = RY_W'(y) + RY_W'(hh) - RY_W'(cy);
      in_x  = !rel_x[RX_W-1] && (rel_x < RX_W'({hw, 1'b0}));
      in_y  = !rel_y[RY_W-1] && (rel_y < RY_W'({hh, 1'b0}));
      hit_c = en && in_x && in_y && (color != TRANS_KEY);
   end

endmodule

// File: rtl/sprite_mixer.sv
// N-channel sprite compositor: priority mux of opaque sprites over background,
// game-state gating of the output, and per-frame player collision flags.
module sprite_mixer #(
   parameter int unsigned        N_SPR      = 4,
   parameter int unsigned        COLOR_W    = game_defs::COLOR_W,
   parameter logic [COLOR_W-1:0] TRANS_KEY  = 12'h000,
   parameter logic [COLOR_W-1:0] BG_KEY     = 12'hFFF,
   parameter logic [COLOR_W-1:0] INIT_COLOR = 12'hF00,
   parameter logic [COLOR_W-1:0] WIN_COLOR  = 12'h00F
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pix_en,
   input  logic [9:0]             x,
   input  logic [8:0]             y,
   input  logic                   frame_start,
   input  logic [1:0]             game_state,
   input  logic [N_SPR-1:0]       spr_en,
   input  logic [N_SPR*10-1:0]    spr_cx,
   input  logic [N_SPR*9-1:0]     spr_cy,
   input  logic [N_SPR*8-1:0]     spr_hw,
   input  logic [N_SPR*8-1:0]     spr_hh,
   input  logic [N_SPR*12-1:0]    spr_color,
   input  logic [COLOR_W-1:0]     bg_color,
   output logic [COLOR_W-1:0]     vga_data,
   output logic                   pix_valid,
   output logic [N_SPR-1:0]       coll_flags,
   output logic                   coll_valid
);
   import game_defs::*;

   localparam int unsigned SPR_CW = 12;

   logic [N_SPR-1:0]    hit_c;

   logic [N_SPR-1:0]    s1_hit;
   logic [COLOR_W-1:0]  s1_color [N_SPR];
   logic [COLOR_W-1:0]  s1_bg;
   game_state_t         s1_state;
   logic                s1_fs;
   logic                s1_valid;

   logic [COLOR_W-1:0]  run_pix_c;
   logic [COLOR_W-1:0]  mix_c;
   logic [N_SPR-1:0]    contrib_c;

   logic [N_SPR-1:0]    acc;
   logic                armed;

   // One box/transparency tester per channel.
   for (genvar i = 0; i < N_SPR; i++) begin : g_hit
      sprite_hit_test #(
         .COLOR_W   (COLOR_W),
         .TRANS_KEY (TRANS_KEY)
      ) u_hit (
         .en    (spr_en[i]),
         .x     (x),
         .y     (y),
         .cx    (spr_cx[i*X_W +: X_W]),
         .cy    (spr_cy[i*Y_W +: Y_W]),
         .hw    (spr_hw[i*HALF_W +: HALF_W]),
         .hh    (spr_hh[i*HALF_W +: HALF_W]),
         .color (COLOR_W'(spr_color[i*SPR_CW +: SPR_CW])),
         .hit_c (hit_c[i])
      );
   end

   // Stage 1: capture hits and everything stage 2 needs for this pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_hit   <= '0;
         s1_bg    <= '0;
         s1_state <= GAME_INITIAL;
         s1_fs    <= 1'b0;
         s1_valid <= 1'b0;
         for (int i = 0; i < int'(N_SPR); i++) s1_color[i] <= '0;
      end else if (pix_en) begin
         s1_hit   <= hit_c;
         s1_bg    <= bg_color;
         s1_state <= game_state_t'(game_state);
         s1_fs    <= frame_start;
         s1_valid <= 1'b1;
         for (int i = 0; i < int'(N_SPR); i++)
            s1_color[i] <= COLOR_W'(spr_color[i*SPR_CW +: SPR_CW]);
      end
   end

   // Priority select (descending loop so the lowest index wins) and state gating.
   always_comb begin
      run_pix_c = (s1_bg == BG_KEY) ? '0 : s1_bg;
      for (int i = int'(N_SPR) - 1; i >= 0; i--) begin
         if (s1_hit[i]) run_pix_c = s1_color[i];
      end
      mix_c = '0;
      case (s1_state)
         GAME_INITIAL: mix_c = INIT_COLOR;
         GAME_RUNNING: mix_c = run_pix_c;
         GAME_OVER:    mix_c = s1_bg;
         GAME_SUCCESS: mix_c = WIN_COLOR;
         default:      mix_c = '0;
      endcase
   end

   // Player-vs-object overlaps contributed by the stage-1 pixel; bit 0 never set.
   always_comb begin
      contrib_c = '0;
      if (s1_state == GAME_RUNNING && s1_hit[0]) contrib_c = {s1_hit[N_SPR-1:1], 1'b0};
   end

   // Stage 2: composited output and its valid flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga_data  <= '0;
         pix_valid <= 1'b0;
      end else if (pix_en) begin
         vga_data  <= mix_c;
         pix_valid <= s1_valid;
      end
   end

   // Collision accumulator; the first frame_start after reset only opens a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc        <= '0;
         armed      <= 1'b0;
         coll_flags <= '0;
         coll_valid <= 1'b0;
      end else begin
         coll_valid <= 1'b0;
         if (pix_en) begin
            if (s1_fs) begin
               if (armed) begin
                  coll_flags <= acc;
                  coll_valid <= 1'b1;
               end
               armed <= 1'b1;
               acc   <= contrib_c;
            end else begin
               acc <= acc | contrib_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_sprite_mixer.sv
// Scoreboard bench for sprite_mixer: directed pixels push expected colours and
// collision flags; a monitor pops and compares as the DUT presents them.
module tb_sprite_mixer;
   import game_defs::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        pix_en;
   logic [9:0]  x;
   logic [8:0]  y;
   logic        frame_start;
   logic [1:0]  game_state;
   logic [3:0]  spr_en;
   logic [39:0] spr_cx;
   logic [35:0] spr_cy;
   logic [31:0] spr_hw;
   logic [31:0] spr_hh;
   logic [47:0] spr_color;
   logic [11:0] bg_color;
   logic [11:0] vga_data;
   logic        pix_valid;
   logic [3:0]  coll_flags;
   logic        coll_valid;

   typedef struct {
      logic        chk;
      logic [11:0] exp;
      string       nm;
   } pix_exp_t;

   pix_exp_t    sb_q[$];
   logic [3:0]  coll_q[$];
   int          total = 0;
   int          bad   = 0;
   logic        strobe_seen;

   sprite_mixer dut (
      .clk         (clk),
      .rst         (rst),
      .pix_en      (pix_en),
      .x           (x),
      .y           (y),
      .frame_start (frame_start),
      .game_state  (game_state),
      .spr_en      (spr_en),
      .spr_cx      (spr_cx),
      .spr_cy      (spr_cy),
      .spr_hw      (spr_hw),
      .spr_hh      (spr_hh),
      .spr_color   (spr_color),
      .bg_color    (bg_color),
      .vga_data    (vga_data),
      .pix_valid   (pix_valid),
      .coll_flags  (coll_flags),
      .coll_valid  (coll_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Remember whether the last rising edge was a pixel strobe.
   always @(posedge clk or posedge rst) begin
      if (rst) strobe_seen <= 1'b0;
      else     strobe_seen <= pix_en;
   end

   // Monitor: compare each presented pixel and each collision update.
   always @(negedge clk) begin
      if (!rst) begin
         if (strobe_seen && pix_valid) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL pix_unexpected: got %0h want no output", vga_data);
            end else begin
               pix_exp_t e;
               e = sb_q.pop_front();
               if (e.chk) check(e.nm, 32'(vga_data), 32'(e.exp));
            end
         end
         if (coll_valid) begin
            if (coll_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL coll_spurious: got flags %0h want no coll_valid", coll_flags);
            end else begin
               logic [3:0] ce;
               ce = coll_q.pop_front();
               check("coll_flags", 32'(coll_flags), 32'(ce));
            end
         end
      end
   end

   task automatic set_spr(input int i, input logic en, input logic [9:0] cx, input logic [8:0] cy,
                          input logic [7:0] hw, input logic [7:0] hh, input logic [11:0] col);
      spr_en[i]          = en;
      spr_cx[i*10 +: 10] = cx;
      spr_cy[i*9 +: 9]   = cy;
      spr_hw[i*8 +: 8]   = hw;
      spr_hh[i*8 +: 8]   = hh;
      spr_color[i*12 +: 12] = col;
   endtask

   task automatic drive(input logic [9:0] px, input logic [8:0] py, input logic fs,
                        input logic chk, input logic [11:0] exp, input string nm);
      pix_exp_t e;
      x = px;
      y = py;
      frame_start = fs;
      pix_en = 1'b1;
      e.chk = chk;
      e.exp = exp;
      e.nm  = nm;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      pix_en = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic gap(input int n);
      pix_en = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no end want end of stimulus");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      pix_en = 1'b0;
      x = '0;
      y = '0;
      frame_start = 1'b0;
      game_state = 2'b01;
      spr_en = '0;
      spr_cx = '0;
      spr_cy = '0;
      spr_hw = '0;
      spr_hh = '0;
      spr_color = '0;
      bg_color = 12'h123;
      repeat (2) @(posedge clk);
      #1;
      check("rst_vga_data", 32'(vga_data), 32'h0);
      check("rst_pix_valid", 32'(pix_valid), 32'h0);
      check("rst_coll_flags", 32'(coll_flags), 32'h0);
      check("rst_coll_valid", 32'(coll_valid), 32'h0);
      rst = 1'b0;
      #1;

      // Opening frame_start after reset produces no coll_valid.
      drive(10'd0, 9'd0, 1'b1, 1'b1, 12'h123, "first_bg");

      // Basic box edges of the player sprite.
      set_spr(0, 1'b1, 10'd100, 9'd100, 8'd15, 8'd20, 12'h0F0);
      drive(10'd85,  9'd80,  1'b0, 1'b1, 12'h0F0, "t1_top_left");
      drive(10'd115, 9'd80,  1'b0, 1'b1, 12'h123, "t1_right_out");
      drive(10'd114, 9'd119, 1'b0, 1'b1, 12'h0F0, "t1_bot_right_in");
      drive(10'd114, 9'd120, 1'b0, 1'b1, 12'h123, "t1_below");

      // Overlap of channels 0 and 1: priority and collision.
      set_spr(0, 1'b1, 10'd200, 9'd150, 8'd15, 8'd20, 12'h0F0);
      set_spr(1, 1'b1, 10'd200, 9'd150, 8'd10, 8'd10, 12'hF00);
      drive(10'd200, 9'd150, 1'b0, 1'b1, 12'h0F0, "t2_prio");
      drive(10'd205, 9'd150, 1'b0, 1'b1, 12'h0F0, "t2_prio2");
      coll_q.push_back(4'b0010);
      drive(10'd0, 9'd0, 1'b1, 1'b1, 12'h123, "t2_fs");
      set_spr(1, 1'b0, 10'd200, 9'd150, 8'd10, 8'd10, 12'hF00);
      drive(10'd200, 9'd150, 1'b0, 1'b1, 12'h0F0, "t2_solo");
      coll_q.push_back(4'b0000);
      drive(10'd0, 9'd0, 1'b1, 1'b1, 12'h123, "t2_fs2");

      // Transparency and background key.
      set_spr(0, 1'b0, 10'd200, 9'd150, 8'd15, 8'd20, 12'h0F0);
      set_spr(1, 1'b1, 10'd200, 9'd150, 8'd10, 8'd10, 12'h000);
      drive(10'd200, 9'd150, 1'b0, 1'b1, 12'h123, "t3_trans_bg");
      bg_color = 12'hFFF;
      drive(10'd200, 9'd150, 1'b0, 1'b1, 12'h000, "t3_bg_key");
      set_spr(1, 1'b1, 10'd200, 9'd150, 8'd10, 8'd10, 12'hF00);
      drive(10'd200, 9'd150, 1'b0, 1'b1, 12'hF00, "t3_ch1_opaque");
      bg_color = 12'h123;

      // Edge clipping and zero-size box.
      set_spr(1, 1'b0, 10'd200, 9'd150, 8'd10, 8'd10, 12'hF00);
      set_spr(2, 1'b1, 10'd5, 9'd100, 8'd15, 8'd10, 12'hABC);
      drive(10'd1015, 9'd100, 1'b0, 1'b1, 12'h123, "t4_no_wrap");
      drive(10'd0,    9'd100, 1'b0, 1'b1, 12'hABC, "t4_clip_hit");
      set_spr(3, 1'b1, 10'd300, 9'd100, 8'd0, 8'd5, 12'h555);
      drive(10'd300, 9'd100, 1'b0, 1'b1, 12'h123, "t4_hw_zero");

      // Game-state gating; overlap while OVER must not accumulate.
      set_spr(2, 1'b0, 10'd5, 9'd100, 8'd15, 8'd10, 12'hABC);
      set_spr(3, 1'b0, 10'd300, 9'd100, 8'd0, 8'd5, 12'h555);
      game_state = 2'b00;
      drive(10'd200, 9'd150, 1'b0, 1'b1, 12'hF00, "t5_initial");
      game_state = 2'b11;
      drive(10'd200, 9'd150, 1'b0, 1'b1, 12'h00F, "t5_success");
      set_spr(0, 1'b1, 10'd200, 9'd150, 8'd15, 8'd20, 12'h0F0);
      set_spr(1, 1'b1, 10'd200, 9'd150, 8'd10, 8'd10, 12'hF00);
      game_state = 2'b10;
      bg_color = 12'hFFF;
      drive(10'd200, 9'd150, 1'b0, 1'b1, 12'hFFF, "t5_over_raw_bg");
      drive(10'd205, 9'd150, 1'b0, 1'b1, 12'hFFF, "t5_over2");
      game_state = 2'b01;
      bg_color = 12'h123;
      coll_q.push_back(4'b0000);
      drive(10'd0, 9'd0, 1'b1, 1'b1, 12'h123, "t5_fs");

      // Strobe toggling, then reset mid-frame.
      drive(10'd200, 9'd150, 1'b0, 1'b1, 12'h0F0, "t6_overlap");
      coll_q.push_back(4'b0010);
      drive(10'd0, 9'd0, 1'b1, 1'b1, 12'h123, "t6_fs");
      gap(1);
      drive(10'd200, 9'd150, 1'b0, 1'b1, 12'h0F0, "t6_tog1");
      gap(1);
      drive(10'd205, 9'd150, 1'b0, 1'b1, 12'h0F0, "t6_tog2");
      gap(1);
      rst = 1'b1;
      #2;
      check("midrst_vga_data", 32'(vga_data), 32'h0);
      check("midrst_pix_valid", 32'(pix_valid), 32'h0);
      check("midrst_coll_flags", 32'(coll_flags), 32'h0);
      check("midrst_coll_valid", 32'(coll_valid), 32'h0);
      sb_q.delete();
      coll_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(10'd0, 9'd0, 1'b1, 1'b1, 12'h123, "t6_fs_after_rst");
      gap(1);
      drive(10'd200, 9'd150, 1'b0, 1'b1, 12'h0F0, "t6_post_overlap");
      gap(1);
      coll_q.push_back(4'b0010);
      drive(10'd0, 9'd0, 1'b1, 1'b1, 12'h123, "t6_fs2");
      gap(1);
      drive(10'd0, 9'd0, 1'b0, 1'b0, 12'h000, "flush1");
      drive(10'd0, 9'd0, 1'b0, 1'b0, 12'h000, "flush2");
      gap(3);
      check("coll_all_seen", 32'(coll_q.size()), 32'd0);
      check("pix_backlog", 32'(sb_q.size()), 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
